bp_be_fe_queue_buffer: RTL and testbench

Circular buffer between the front end and back-end issue that holds `bp_fe_queue_s` packets (fetched PC/instruction, or exception messages) produced by the FE. It decouples FE fetch from BE issue. It keeps a checkpoint pointer so that issued-but-uncommitted packets can be replayed after a back-end rollback. It also supports a full flush when the BE redirects the FE.

---
 rtl/bp_be_fe_queue_buffer_pkg.sv | 12 +
 rtl/bsg_mem_1r1w.sv | 31 +++
 rtl/bp_be_fe_queue_buffer.sv | 94 +++++++++
 tb/tb_bp_be_fe_queue_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared defaults and elaboration helpers for the FE->BE issue queue buffer.
package bp_be_fe_queue_buffer_pkg;

  localparam int unsigned fe_queue_width_default = 128;
  localparam int unsigned els_default            = 16;

  // True when n is a power of two no smaller than 2.
  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register file with a combinational read port; contents are not reset.
module bsg_mem_1r1w #(
  parameter int unsigned width_p                = 8,
  parameter int unsigned els_p                  = 4,
  parameter int unsigned read_write_same_addr_p = 0,
  localparam int unsigned addr_width_lp         = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem[r_addr_i];

  // A same-entry read and write in one cycle is only allowed when the parameter permits it.
  always_ff @(posedge w_clk_i) begin
    if (read_write_same_addr_p == 0 && r_v_i && w_v_i)
      assert (r_addr_i != w_addr_i);
  end

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Circular FE->BE packet buffer with a checkpoint pointer for replay after rollback and a full flush.
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter int unsigned fe_queue_width_p = fe_queue_width_default,
  parameter int unsigned els_p            = els_default
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [fe_queue_width_p-1:0] fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_o,
  output logic [fe_queue_width_p-1:0] issue_pkt_o,
  output logic                        issue_v_o,
  input  logic                        issue_yumi_i,
  input  logic                        inc_v_i,
  input  logic                        roll_v_i,
  input  logic                        clr_v_i,
  output logic                        empty_o,
  output logic                        full_o
);

  localparam int unsigned ptr_width_lp  = $clog2(els_p) + 1;
  localparam int unsigned addr_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic enq, deq, inc, full;

  // Full when write and checkpoint index the same slot one lap apart.
  assign full = (wptr[addr_width_lp-1:0] == cptr[addr_width_lp-1:0])
              && (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);

  assign full_o           = full;
  assign empty_o          = (wptr == cptr);
  assign issue_v_o        = (rptr != wptr);
  assign fe_queue_ready_o = reset_i & ~full & ~clr_v_i;

  assign enq = fe_queue_v_i & fe_queue_ready_o;
  assign deq = issue_yumi_i & issue_v_o;
  assign inc = inc_v_i & (cptr != rptr);

  // Clear beats roll beats normal traffic; roll lands on the post-commit checkpoint.
  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    cptr_n = cptr;
    if (clr_v_i) begin
      rptr_n = wptr;
      cptr_n = wptr;
    end else begin
      wptr_n = wptr + ptr_width_lp'(enq);
      cptr_n = cptr + ptr_width_lp'(inc);
      if (roll_v_i) rptr_n = cptr_n;
      else          rptr_n = rptr + ptr_width_lp'(deq);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p               (fe_queue_width_p),
    .els_p                 (els_p),
    .read_write_same_addr_p(0)
  ) mem (
    .w_clk_i (clk_i),
    .w_v_i   (enq),
    .w_addr_i(wptr[addr_width_lp-1:0]),
    .w_data_i(fe_queue_i),
    .r_v_i   (issue_v_o),
    .r_addr_i(rptr[addr_width_lp-1:0]),
    .r_data_o(issue_pkt_o)
  );

  // Sizing and protocol checks for simulation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      assert (is_pow2(els_p));
      if (inc_v_i && !clr_v_i) assert (cptr != rptr);
      if (issue_yumi_i) assert (issue_v_o);
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Self-checking bench: directed vector table, async reset sequence, then random traffic vs a queue model.
module tb_bp_be_fe_queue_buffer;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_v_i, fe_queue_ready_o;
  logic [W-1:0] issue_pkt_o;
  logic         issue_v_o, issue_yumi_i, inc_v_i, roll_v_i, clr_v_i, empty_o, full_o;

  always #5 clk = ~clk;

  bp_be_fe_queue_buffer #(.fe_queue_width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .issue_pkt_o(issue_pkt_o), .issue_v_o(issue_v_o), .issue_yumi_i(issue_yumi_i),
    .inc_v_i(inc_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i),
    .empty_o(empty_o), .full_o(full_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: occupied packets oldest-first, and how many of them are issued.
  logic [W-1:0] mq[$];
  int           issued = 0;

  function automatic bit m_full();  return mq.size() == N; endfunction
  function automatic bit m_empty(); return mq.size() == 0; endfunction
  function automatic bit m_iv();    return issued < mq.size(); endfunction

  task automatic model_step();
    bit pre_iv, pre_full;
    pre_iv   = m_iv();
    pre_full = m_full();
    if (clr_v_i) begin
      mq.delete();
      issued = 0;
    end else begin
      if (fe_queue_v_i && !pre_full) mq.push_back(fe_queue_i);
      if (inc_v_i && issued > 0) begin
        mq.delete(0);
        issued--;
      end
      if (roll_v_i) issued = 0;
      else if (issue_yumi_i && pre_iv) issued++;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic y,
                       input logic i, input logic r, input logic c);
    @(negedge clk);
    fe_queue_v_i = v; fe_queue_i = d; issue_yumi_i = y;
    inc_v_i = i; roll_v_i = r; clr_v_i = c;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, W'(fe_queue_ready_o), W'(!m_full() && !clr_v_i));
    chk({tag, ".issue_v"}, W'(issue_v_o), W'(m_iv()));
    chk({tag, ".empty"}, W'(empty_o), W'(m_empty()));
    chk({tag, ".full"}, W'(full_o), W'(m_full()));
    if (m_iv()) chk({tag, ".pkt"}, issue_pkt_o, mq[issued]);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic v; logic [W-1:0] d; logic y, i, r, c;
    logic e_rdy, e_iv; logic [W-1:0] e_pkt; logic e_empty, e_full;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [W-1:0] d, input logic y, input logic i,
                     input logic r, input logic c, input logic e_rdy, input logic e_iv,
                     input logic [W-1:0] e_pkt, input logic e_empty, input logic e_full);
    vec_t t;
    t.v = v; t.d = d; t.y = y; t.i = i; t.r = r; t.c = c;
    t.e_rdy = e_rdy; t.e_iv = e_iv; t.e_pkt = e_pkt; t.e_empty = e_empty; t.e_full = e_full;
    tbl.push_back(t);
  endtask

  initial begin
    reset_i = 1'b0;
    fe_queue_v_i = 0; fe_queue_i = '0; issue_yumi_i = 0; inc_v_i = 0; roll_v_i = 0; clr_v_i = 0;

    //        v  data   y  i  r  c | rdy iv pkt    empty full
    // fill to full, E held off, drain issue, commit frees space
    add(1, 'hA,   0, 0, 0, 0,  1, 0, 'h0,  1, 0);
    add(1, 'hB,   0, 0, 0, 0,  1, 1, 'hA,  0, 0);
    add(1, 'hC,   0, 0, 0, 0,  1, 1, 'hA,  0, 0);
    add(1, 'hD,   0, 0, 0, 0,  1, 1, 'hA,  0, 0);
    add(1, 'hE,   1, 0, 0, 0,  0, 1, 'hA,  0, 1);
    add(1, 'hE,   1, 0, 0, 0,  0, 1, 'hB,  0, 1);
    add(1, 'hE,   1, 0, 0, 0,  0, 1, 'hC,  0, 1);
    add(1, 'hE,   1, 0, 0, 0,  0, 1, 'hD,  0, 1);
    add(1, 'hE,   0, 1, 0, 0,  0, 0, 'h0,  0, 1);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    // roll back to the checkpoint and replay
    add(1, 'h11,  0, 0, 0, 0,  1, 0, 'h0,  1, 0);
    add(1, 'h22,  0, 0, 0, 0,  1, 1, 'h11, 0, 0);
    add(1, 'h33,  1, 0, 0, 0,  1, 1, 'h11, 0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h22, 0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 1, 'h33, 0, 0);
    add(0, 'h0,   0, 0, 1, 0,  1, 1, 'h33, 0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h22, 0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h33, 0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    // roll together with commit
    add(1, 'h44,  0, 0, 0, 0,  1, 0, 'h0,  1, 0);
    add(1, 'h55,  0, 0, 0, 0,  1, 1, 'h44, 0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h44, 0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h55, 0, 0);
    add(0, 'h0,   0, 1, 1, 0,  1, 0, 'h0,  0, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'h55, 0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    // clear with simultaneous enqueue and yumi, then enqueue right after
    add(1, 'h66,  0, 0, 0, 0,  1, 0, 'h0,  1, 0);
    add(1, 'h77,  0, 0, 0, 0,  1, 1, 'h66, 0, 0);
    add(1, 'h88,  0, 0, 0, 0,  1, 1, 'h66, 0, 0);
    add(1, 'h99,  1, 0, 0, 1,  0, 1, 'h66, 0, 0);
    add(1, 'hAA,  0, 0, 0, 0,  1, 0, 'h0,  1, 0);
    add(0, 'h0,   1, 0, 0, 0,  1, 1, 'hAA, 0, 0);
    add(0, 'h0,   0, 1, 0, 0,  1, 0, 'h0,  0, 0);
    add(0, 'h0,   0, 0, 0, 0,  1, 0, 'h0,  1, 0);

    #12;
    chk("reset.ready", W'(fe_queue_ready_o), W'(0));
    chk("reset.issue_v", W'(issue_v_o), W'(0));
    chk("reset.empty", W'(empty_o), W'(1));
    chk("reset.full", W'(full_o), W'(0));
    @(negedge clk);
    reset_i = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].y, tbl[k].i, tbl[k].r, tbl[k].c);
      chk($sformatf("tbl[%0d].ready", k), W'(fe_queue_ready_o), W'(tbl[k].e_rdy));
      chk($sformatf("tbl[%0d].issue_v", k), W'(issue_v_o), W'(tbl[k].e_iv));
      chk($sformatf("tbl[%0d].empty", k), W'(empty_o), W'(tbl[k].e_empty));
      chk($sformatf("tbl[%0d].full", k), W'(full_o), W'(tbl[k].e_full));
      if (tbl[k].e_iv) chk($sformatf("tbl[%0d].pkt", k), issue_pkt_o, tbl[k].e_pkt);
      finish_cycle();
    end

    // Full-throughput enqueue/issue/commit across several pointer wraps.
    for (int k = 0; k < 3 * N + 2; k++) begin
      drive(1, W'(32'h1000 + k), m_iv(), issued > 0, 0, 0);
      check_model($sformatf("wrap[%0d]", k));
      finish_cycle();
    end

    // Asynchronous reset between edges with two entries held.
    drive(0, '0, 0, 0, 0, 1);
    finish_cycle();
    drive(1, 'hB1, 0, 0, 0, 0);
    finish_cycle();
    drive(1, 'hB2, 0, 0, 0, 0);
    check_model("areset.pre");
    finish_cycle();
    fe_queue_v_i = 0;
    #3;
    reset_i = 1'b0;
    #1;
    chk("areset.ready", W'(fe_queue_ready_o), W'(0));
    chk("areset.issue_v", W'(issue_v_o), W'(0));
    chk("areset.empty", W'(empty_o), W'(1));
    chk("areset.full", W'(full_o), W'(0));
    mq.delete();
    issued = 0;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("release.ready", W'(fe_queue_ready_o), W'(1));
    chk("release.issue_v", W'(issue_v_o), W'(0));

    // Random legal traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom),
            m_iv() && ($urandom_range(0, 2) != 0),
            (issued > 0) && ($urandom_range(0, 2) != 0),
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
      check_model($sformatf("rand[%0d]", k));
      finish_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
